sdram_68k_master: RTL and testbench



---
 rtl/sdram_68k_master.sv | 192 +++++++++++++++++++
 tb/tb_sdram_68k_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_68k_master.sv
// sdram_68k_master: 68K-style asn/udsn/ldsn/rw initiator for the SDRAM controller.
// Optional macro SDRAM_68K_MASTER_CNT_EN adds rd_count/wr_count completion counters.
`timescale 1ns/1ps

module sdram_68k_master #(
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic        clk100_mhz,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [23:0] bus_addr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    output logic        bus_asn,
    output logic        bus_udsn,
    output logic        bus_ldsn,
`ifdef SDRAM_68K_MASTER_CNT_EN
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
`endif
    output logic        bus_rw
);

    localparam logic [4:0] SETUP_LD = 5'(SETUP_CYCLES);
    localparam logic [4:0] HOLD_LD  = 5'(HOLD_CYCLES);
    localparam logic [4:0] GAP_LD   = 5'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [4:0]  cnt_d;
    logic        cnt_last;
    logic        ready_q;
    logic        we_q;
    logic [1:0]  be_q;
    logic        asn_q;
    logic        udsn_q;
    logic        ldsn_q;
    logic        rw_q;
    logic [23:0] addr_q;
    logic [15:0] dout_q;
    logic        rsp_valid_q;
    logic [15:0] rdata_q;

    // Shared phase timer: a phase ends on the cycle its count reads 1.
    always_comb begin
        cnt_d    = cnt_q - 5'd1;
        cnt_last = (cnt_q == 5'd1);
    end

    // Transfer sequencer: accept, setup, strobe, recover.
    always_ff @(posedge clk100_mhz) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            be_q        <= 2'b00;
            asn_q       <= 1'b1;
            udsn_q      <= 1'b1;
            ldsn_q      <= 1'b1;
            rw_q        <= 1'b1;
            addr_q      <= 24'h0;
            dout_q      <= 16'h0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 16'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        we_q    <= req_we;
                        be_q    <= req_be;
                        addr_q  <= req_addr;
                        dout_q  <= req_wdata;
                        rw_q    <= ~req_we;
                        ready_q <= 1'b0;
                        if (req_be == 2'b00) begin
                            // Nothing to strobe: complete without bus activity.
                            state_q     <= RECOVER;
                            cnt_q       <= GAP_LD;
                            rsp_valid_q <= 1'b1;
                            if (!req_we) begin
                                rdata_q <= 16'h0;
                            end
                        end else begin
                            asn_q   <= 1'b0;
                            state_q <= SETUP;
                            cnt_q   <= SETUP_LD;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_last) begin
                        udsn_q  <= ~be_q[1];
                        ldsn_q  <= ~be_q[0];
                        state_q <= STROBE;
                        cnt_q   <= HOLD_LD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STROBE: begin
                    if (cnt_last) begin
                        if (!we_q) begin
                            rdata_q <= bus_din;
                        end
                        asn_q       <= 1'b1;
                        udsn_q      <= 1'b1;
                        ldsn_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RECOVER;
                        cnt_q       <= GAP_LD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RECOVER: begin
                    if (cnt_last) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Ready is masked while rst is high so the reset cycle never advertises acceptance.
    assign req_ready = ready_q & ~rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign bus_addr  = addr_q;
    assign bus_dout  = dout_q;
    assign bus_asn   = asn_q;
    assign bus_udsn  = udsn_q;
    assign bus_ldsn  = ldsn_q;
    assign bus_rw    = rw_q;

`ifdef SDRAM_68K_MASTER_CNT_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] rd_cnt_d;
    logic [15:0] wr_cnt_q;
    logic [15:0] wr_cnt_d;

    // Saturating completion counters, bumped on the response pulse.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rsp_valid_q && !we_q && rd_cnt_q != 16'hFFFF) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (rsp_valid_q && we_q && wr_cnt_q != 16'hFFFF) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk100_mhz) begin
        if (rst) begin
            rd_cnt_q <= 16'h0;
            wr_cnt_q <= 16'h0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_68k_master.sv
// tb_sdram_68k_master: directed plus random transfers against a cycle-level
// expectation model and a behavioural SDRAM controller.
`timescale 1ns/1ps

module tb_sdram_68k_master;

    localparam int S = 2;
    localparam int H = 16;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [23:0] req_addr;
    logic [1:0]  req_be;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [23:0] bus_addr;
    logic [15:0] bus_dout;
    logic [15:0] bus_din;
    logic        bus_asn;
    logic        bus_udsn;
    logic        bus_ldsn;
    logic        bus_rw;
`ifdef SDRAM_68K_MASTER_CNT_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_rdata;
    int          exp_rd;
    int          exp_wr;
    logic [15:0] ref_mem [256];
    logic [15:0] sdram [256];
    logic        mem_init;

    always #5 clk = ~clk;

    sdram_68k_master #(
        .SETUP_CYCLES(S),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G)
    ) dut (
        .clk100_mhz(clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .bus_addr  (bus_addr),
        .bus_dout  (bus_dout),
        .bus_din   (bus_din),
        .bus_asn   (bus_asn),
        .bus_udsn  (bus_udsn),
        .bus_ldsn  (bus_ldsn),
`ifdef SDRAM_68K_MASTER_CNT_EN
        .rd_count  (rd_count),
        .wr_count  (wr_count),
`endif
        .bus_rw    (bus_rw)
    );

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    // Behavioural controller: serves reads while asn is low, writes strobed bytes.
    assign bus_din = (!bus_asn && bus_rw) ? sdram[bus_addr[7:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) sdram[i] <= init_val(i);
        end else if (!bus_asn && !bus_rw) begin
            if (!bus_udsn) sdram[bus_addr[7:0]][15:8] <= bus_dout[15:8];
            if (!bus_ldsn) sdram[bus_addr[7:0]][7:0] <= bus_dout[7:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_counts();
`ifdef SDRAM_68K_MASTER_CNT_EN
        chk("rd_count", 32'(rd_count), 32'(exp_rd));
        chk("wr_count", 32'(wr_count), 32'(exp_wr));
`endif
    endtask

    // Called at a negedge where the block should be idle and ready.
    task automatic txn(input logic we, input logic [23:0] addr,
                       input logic [1:0] be, input logic [15:0] wd,
                       input bit hold);
        int          rspk;
        int          endk;
        logic        strb;
        logic [15:0] old_rd;
        logic [15:0] new_rd;
        rspk   = (be == 2'b00) ? 1 : S + H + 1;
        endk   = (be == 2'b00) ? G + 1 : S + H + G + 1;
        old_rd = exp_rdata;
        if (we) new_rd = old_rd;
        else if (be == 2'b00) new_rd = 16'h0;
        else new_rd = ref_mem[addr[7:0]];
        chk("ready_at_issue", 32'(req_ready), 32'd1);
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int k = 1; k <= endk; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) req_valid = 1'b0;
            strb = (be != 2'b00) && (k >= S + 1) && (k <= S + H);
            chk($sformatf("asn c%0d", k), 32'(bus_asn),
                32'(!((be != 2'b00) && (k <= S + H))));
            chk($sformatf("udsn c%0d", k), 32'(bus_udsn), 32'(!(strb && be[1])));
            chk($sformatf("ldsn c%0d", k), 32'(bus_ldsn), 32'(!(strb && be[0])));
            chk($sformatf("rsp_valid c%0d", k), 32'(rsp_valid), 32'(k == rspk));
            chk($sformatf("ready c%0d", k), 32'(req_ready), 32'(k == endk));
            chk($sformatf("rdata c%0d", k), 32'(rsp_rdata),
                32'((k >= rspk) ? new_rd : old_rd));
            chk($sformatf("addr c%0d", k), 32'(bus_addr), 32'(addr));
            chk($sformatf("rw c%0d", k), 32'(bus_rw), 32'(!we));
            chk($sformatf("dout c%0d", k), 32'(bus_dout), 32'(wd));
        end
        exp_rdata = new_rd;
        if (we) begin
            if (be[1]) ref_mem[addr[7:0]][15:8] = wd[15:8];
            if (be[0]) ref_mem[addr[7:0]][7:0] = wd[7:0];
            if (exp_wr < 65535) exp_wr++;
        end else begin
            if (exp_rd < 65535) exp_rd++;
        end
        chk_counts();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        exp_rdata = 16'h0;
        exp_rd    = 0;
        exp_wr    = 0;
        mem_init  = 1'b1;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 24'h000123;
        req_be    = 2'b11;
        req_wdata = 16'h0;

        // Reset state, with a request offered during rst.
        @(negedge clk);
        @(negedge clk);
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst asn", 32'(bus_asn), 32'd1);
        chk("rst udsn", 32'(bus_udsn), 32'd1);
        chk("rst ldsn", 32'(bus_ldsn), 32'd1);
        chk("rst rw", 32'(bus_rw), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rdata", 32'(rsp_rdata), 32'd0);
        chk("rst addr", 32'(bus_addr), 32'd0);
        chk("rst dout", 32'(bus_dout), 32'd0);
        rst       = 1'b0;
        mem_init  = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst asn", 32'(bus_asn), 32'd1);
        chk_counts();

        // Full write, read-back, byte-lane write and merge.
        txn(1'b1, 24'h000123, 2'b11, 16'hBEEF, 1'b0);
        txn(1'b0, 24'h000123, 2'b11, 16'h0000, 1'b0);
        chk("readback BEEF", 32'(rsp_rdata), 32'h0000BEEF);
        txn(1'b1, 24'h000123, 2'b10, 16'h12A5, 1'b0);
        txn(1'b0, 24'h000123, 2'b11, 16'h0000, 1'b0);
        chk("merge 12EF", 32'(rsp_rdata), 32'h000012EF);

        // Back-to-back with req_valid held high.
        txn(1'b0, 24'h000123, 2'b11, 16'h1111, 1'b1);
        txn(1'b1, 24'h000140, 2'b11, 16'h5555, 1'b1);
        txn(1'b0, 24'h000140, 2'b01, 16'h2222, 1'b0);

        // Reset in the middle of a read strobe.
        chk("mid ready", 32'(req_ready), 32'd1);
        req_we    = 1'b0;
        req_addr  = 24'h000123;
        req_be    = 2'b11;
        req_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            chk($sformatf("mid asn c%0d", k), 32'(bus_asn), 32'd0);
            chk($sformatf("mid udsn c%0d", k), 32'(bus_udsn), 32'(k <= S));
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_rdata = 16'h0;
        exp_rd    = 0;
        exp_wr    = 0;
        for (int k = 11; k <= 25; k++) begin
            @(negedge clk);
            chk($sformatf("rst asn c%0d", k), 32'(bus_asn), 32'd1);
            chk($sformatf("rst udsn c%0d", k), 32'(bus_udsn), 32'd1);
            chk($sformatf("rst ldsn c%0d", k), 32'(bus_ldsn), 32'd1);
            chk($sformatf("rst ready c%0d", k), 32'(req_ready), 32'd1);
            chk($sformatf("rst rsp c%0d", k), 32'(rsp_valid), 32'd0);
            chk($sformatf("rst rdata c%0d", k), 32'(rsp_rdata), 32'd0);
        end
        chk_counts();
        txn(1'b0, 24'h000123, 2'b11, 16'h0000, 1'b0);

        // Empty byte enables: no strobes, zero read data.
        txn(1'b0, 24'h000055, 2'b00, 16'h0000, 1'b0);
        txn(1'b1, 24'h000056, 2'b00, 16'h7777, 1'b0);

        // Random traffic over a small address window.
        for (int n = 0; n < 24; n++) begin
            txn(1'($urandom), {16'($urandom), 8'($urandom_range(0, 7))},
                2'($urandom), 16'($urandom), 1'($urandom));
        end
        req_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
